// File: rtl/plot_pkg.sv
// plot_pkg: shared constants, types and address helper for the plot sink.
package plot_pkg;

    localparam int FIFO_DEPTH = 16;
    localparam int H_RES      = 160;
    localparam int V_RES      = 120;
    localparam int ADDR_W     = 15;
    localparam int COLOUR_W   = 3;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        CLEAR
    } plot_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic [COLOUR_W-1:0] colour;
    } pixel_t;

    // y*160 + x without a multiplier.
    function automatic logic [ADDR_W-1:0] xy_to_addr(
        input logic [7:0] x,
        input logic [7:0] y
    );
        logic [ADDR_W-1:0] yy;
        yy = ADDR_W'(y);
        return (yy << 7) + (yy << 5) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/plot_fifo.sv
// plot_fifo: synchronous pixel FIFO with flush; flush beats push and pop.
module plot_fifo
    import plot_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  pixel_t                 din,
    output pixel_t                 dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    pixel_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [LVL_W-1:0] lvl_q, lvl_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (lvl_q == LVL_W'(DEPTH));
    assign empty   = (lvl_q == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = mem_q[rd_q];
    assign level   = lvl_q;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        lvl_d = lvl_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            lvl_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + PTR_W'(1);
            if (do_pop)  rd_d = rd_q + PTR_W'(1);
            lvl_d = lvl_q + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            lvl_q <= lvl_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/plot_sink.sv
// plot_sink: buffers plot requests and drains them into a shared framebuffer port.
// Optional PLOT_SINK_OOB_COUNT_EN adds a saturating out-of-range plot counter.
module plot_sink
    import plot_pkg::*;
#(
    parameter int FIFO_DEPTH = plot_pkg::FIFO_DEPTH,
    parameter int H_RES      = plot_pkg::H_RES,
    parameter int V_RES      = plot_pkg::V_RES,
    parameter int ADDR_W     = plot_pkg::ADDR_W,
    parameter int COLOUR_W   = plot_pkg::COLOUR_W
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        plot,
    input  logic [7:0]                  x,
    input  logic [7:0]                  y,
    input  logic [COLOUR_W-1:0]         colour,
    output logic                        plot_ready,
    input  logic                        clear_req,
    input  logic [COLOUR_W-1:0]         clear_colour,
    output logic                        clear_busy,
    input  logic                        scan_rd,
    input  logic [ADDR_W-1:0]           scan_addr,
    output logic                        scan_valid,
    output logic [COLOUR_W-1:0]         scan_data,
    output logic [ADDR_W-1:0]           fb_addr,
    output logic                        fb_we,
    output logic [COLOUR_W-1:0]         fb_wdata,
    input  logic [COLOUR_W-1:0]         fb_rdata,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
`ifdef PLOT_SINK_OOB_COUNT_EN
    ,
    output logic [15:0]                 oob_count
`endif
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(H_RES * V_RES - 1);

    plot_state_t         state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [COLOUR_W-1:0] col_q, col_d;
    logic                scan_valid_q, scan_valid_d;

    logic   fifo_full;
    logic   fifo_empty;
    pixel_t fifo_din;
    pixel_t fifo_dout;

    logic scan_go;
    logic in_range;
    logic accept;
    logic push;
    logic pop;
    logic clr_we;

    assign scan_go    = scan_rd && resetn;
    assign in_range   = (int'(x) < H_RES) && (int'(y) < V_RES);
    assign plot_ready = resetn && !fifo_full && (state_q != CLEAR);
    assign accept     = plot && plot_ready;
    assign push       = accept && in_range;
    assign fifo_din   = '{addr: xy_to_addr(x, y), colour: colour};

    // A clear request pre-empts whatever write this cycle would have made.
    assign pop    = (state_q == DRAIN) && !scan_go && !fifo_empty && !clear_req;
    assign clr_we = (state_q == CLEAR) && !scan_go && !clear_req;

    plot_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (resetn),
        .push  (push),
        .pop   (pop),
        .flush (clear_req),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear_req) begin
            state_d = CLEAR;
        end else begin
            unique case (state_q)
                IDLE:  if (!fifo_empty) state_d = DRAIN;
                DRAIN: begin
                    if ((fifo_empty || (fifo_level == LVL_W'(1) && pop)) && !push)
                        state_d = IDLE;
                end
                CLEAR: if (clr_we && cnt_q == FB_LAST) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d        = cnt_q;
        col_d        = col_q;
        scan_valid_d = scan_go;
        if (clear_req) begin
            cnt_d = '0;
            col_d = clear_colour;
        end else if (clr_we) begin
            cnt_d = (cnt_q == FB_LAST) ? '0 : cnt_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q        <= '0;
            col_q        <= '0;
            scan_valid_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            col_q        <= col_d;
            scan_valid_q <= scan_valid_d;
        end
    end

    always_comb begin
        fb_addr  = '0;
        fb_we    = 1'b0;
        fb_wdata = '0;
        unique case (1'b1)
            scan_go: fb_addr = scan_addr;
            clr_we: begin
                fb_addr  = cnt_q;
                fb_we    = 1'b1;
                fb_wdata = col_q;
            end
            pop: begin
                fb_addr  = fifo_dout.addr;
                fb_we    = 1'b1;
                fb_wdata = fifo_dout.colour;
            end
            default: ;
        endcase
    end

    assign clear_busy = (state_q == CLEAR);
    assign scan_valid = scan_valid_q;
    assign scan_data  = scan_valid_q ? fb_rdata : '0;

`ifdef PLOT_SINK_OOB_COUNT_EN
    logic [15:0] oob_q, oob_d;

    always_comb begin
        oob_d = oob_q;
        if (clear_req)
            oob_d = '0;
        else if (accept && !in_range && oob_q != 16'hFFFF)
            oob_d = oob_q + 16'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) oob_q <= '0;
        else         oob_q <= oob_d;
    end

    assign oob_count = oob_q;
`endif

endmodule
